// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR tap sequencer. Owns the sample delay line, walks one shared
// multiplier across every tap, accumulates with guard bits and emits one saturated
// output sample per accepted input.
module fir_mac_sequencer #(
    parameter int unsigned N     = 16,
    parameter int unsigned Q     = 14,
    parameter int unsigned TAPS  = 8,
    parameter int unsigned AW    = $clog2(TAPS),
    parameter int unsigned GUARD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_sample,
    output logic [AW-1:0] coef_addr,
    input  logic [N:0]    coef_data,
    output logic [N-1:0]  mul_a,
    output logic [N:0]    mul_b,
    input  logic [N-1:0]  mul_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sample,
    output logic          busy
);

    localparam int unsigned ACC_W = N + GUARD;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    // Products arrive already scaled, so Q only constrains legal parameter sets.
    if (TAPS < 2 || Q >= N) begin : g_param_check
        $error("fir_mac_sequencer: need TAPS >= 2 and Q < N");
    end

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       line_q [TAPS];
    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       out_sample_q, out_sample_d;
    logic               line_clr, line_wr;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wp_inc;
    logic [ACC_W-1:0]   sum;
    logic [N-1:0]       sum_sat;
    logic [GUARD:0]     sum_top;

    // Tap k reads the sample k steps older than the newest one, wrapping modulo TAPS.
    always_comb begin
        if (wp_q >= k_q) begin
            rd_idx = wp_q - k_q;
        end else begin
            rd_idx = AW'(TAPS - 32'(k_q) + 32'(wp_q));
        end
        wp_inc = (wp_q == LAST_TAP) ? '0 : wp_q + AW'(1);
    end

    // Accumulate the current product and clamp the running total to N bits.
    always_comb begin
        sum     = acc_q + {{GUARD{mul_p[N-1]}}, mul_p};
        sum_top = sum[ACC_W-1:N-1];
        if (sum_top == '0 || sum_top == '1) begin
            sum_sat = sum[N-1:0];
        end else if (sum[ACC_W-1]) begin
            sum_sat = {1'b1, {(N-1){1'b0}}};
        end else begin
            sum_sat = {1'b0, {(N-1){1'b1}}};
        end
    end

    // Next-state and datapath control; multiplier ports are parked at zero outside MAC.
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        k_d          = k_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_sample_d = out_sample_q;
        line_clr     = 1'b0;
        line_wr      = 1'b0;
        in_ready     = 1'b0;
        coef_addr    = '0;
        mul_a        = '0;
        mul_b        = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = ~flush;
                if (flush) begin
                    line_clr = 1'b1;
                    wp_d     = '0;
                end else if (in_valid) begin
                    line_wr = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                coef_addr = k_q;
                mul_a     = line_q[rd_idx];
                mul_b     = coef_data;
                acc_d     = sum;
                if (k_q == LAST_TAP) begin
                    k_d          = '0;
                    wp_d         = wp_inc;
                    out_sample_d = sum_sat;
                    out_valid_d  = 1'b1;
                    state_d      = StOut;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wp_q         <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
        end
    end

    // Delay line: bulk clear on flush, otherwise write the accepted sample at wp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAPS); i++) line_q[i] <= '0;
        end else if (line_clr) begin
            for (int i = 0; i < int'(TAPS); i++) line_q[i] <= '0;
        end else if (line_wr) begin
            line_q[wp_q] <= in_sample;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural sign-magnitude Q14 multiplier
// and a small coefficient ROM.
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = '0;
    logic [2:0]  coef_addr;
    logic [16:0] coef_data;
    logic [15:0] mul_a;
    logic [16:0] mul_b;
    logic [15:0] mul_p;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sample;
    logic        busy;

    logic [16:0]        coefs [8];
    logic signed [16:0] coef_s;
    logic signed [33:0] prod;

    int tests = 0;
    int fails = 0;

    fir_mac_sequencer #(
        .N(16), .Q(14), .TAPS(8), .AW(3), .GUARD(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign coef_data = coefs[coef_addr];

    // Sign-magnitude coefficient times two's complement sample, Q14, truncated.
    always_comb begin
        coef_s = mul_b[16] ? -$signed({1'b0, mul_b[15:0]}) : $signed({1'b0, mul_b[15:0]});
        prod   = $signed(mul_a) * coef_s;
        mul_p  = prod[29:14];
    end

    task automatic set_impulse_coefs();
        for (int i = 0; i < 8; i++) coefs[i] = 17'h00000;
        coefs[0] = 17'h02000;
        coefs[1] = 17'h11000;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Push one sample through with out_ready high; returns the result and a timeout flag.
    task automatic feed(input logic [15:0] x, output logic [15:0] y, output bit ok);
        in_sample = x;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        y  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                y  = out_sample;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_sample !== 16'h0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b out_sample=%h busy=%b, want 0/0000/0",
                     out_valid, out_sample, busy);
        end
        tests++;
        if (coef_addr !== 3'd0 || mul_a !== 16'h0 || mul_b !== 17'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mac_ports: coef_addr=%0d mul_a=%h mul_b=%h in_ready=%b, want 0/0/0/1",
                     coef_addr, mul_a, mul_b, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        logic [15:0] exp_v [8];
        logic [15:0] y;
        bit ok;
        exp_v = '{16'h2000, 16'hF000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        set_impulse_coefs();
        do_flush();
        for (int i = 0; i < 8; i++) begin
            feed((i == 0) ? 16'h4000 : 16'h0000, y, ok);
            tests++;
            if (!ok || y !== exp_v[i]) begin
                fails++;
                $display("FAIL impulse[%0d]: got %h (valid_seen=%b), want %h", i, y, ok, exp_v[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic exp_rdy;
        logic exp_ov;
        logic [2:0] exp_addr;
        set_impulse_coefs();
        in_sample = 16'h1234;
        in_valid  = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL latency_accept: in_ready=%b, want 1", in_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            exp_rdy  = (c == 10);
            exp_ov   = (c == 9);
            exp_addr = (c >= 1 && c <= 8) ? 3'(c - 1) : 3'd0;
            tests++;
            if (in_ready !== exp_rdy || out_valid !== exp_ov || coef_addr !== exp_addr) begin
                fails++;
                $display("FAIL latency_t+%0d: in_ready=%b out_valid=%b coef_addr=%0d, want %b/%b/%0d",
                         c, in_ready, out_valid, coef_addr, exp_rdy, exp_ov, exp_addr);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [15:0] y;
        bit ok;
        for (int i = 0; i < 8; i++) coefs[i] = 17'h04000;
        do_flush();
        for (int i = 0; i < 8; i++) feed(16'h7FFF, y, ok);
        tests++;
        if (!ok || y !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_pos: got %h (valid_seen=%b), want 7fff", y, ok);
        end
        feed(16'h8000, y, ok);
        tests++;
        if (!ok || y !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_mixed: got %h (valid_seen=%b), want 7fff", y, ok);
        end
        for (int i = 0; i < 7; i++) feed(16'h8000, y, ok);
        tests++;
        if (!ok || y !== 16'h8000) begin
            fails++;
            $display("FAIL sat_neg: got %h (valid_seen=%b), want 8000", y, ok);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        set_impulse_coefs();
        do_flush();
        out_ready = 1'b0;
        in_sample = 16'h1000;
        in_valid  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || out_sample !== 16'h0800) begin
            fails++;
            $display("FAIL bp_first: out_sample=%h valid_seen=%b, want 0800", out_sample, seen);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_sample !== 16'h0800 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_sample=%h in_ready=%b, want 1/0800/0",
                         i, out_valid, out_sample, in_ready);
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_transfer: out_valid=%b, want 1", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b busy=%b, want 0/0", out_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_wrap();
        logic [15:0] y;
        bit ok;
        set_impulse_coefs();
        do_flush();
        for (int i = 0; i < 11; i++) feed(16'h0400, y, ok);
        tests++;
        if (!ok || y !== 16'h0100) begin
            fails++;
            $display("FAIL wrap_steady: got %h (valid_seen=%b), want 0100", y, ok);
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'h7000;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_in_ready: in_ready=%b, want 0", in_ready);
        end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_accept: busy=%b, want 0", busy);
        end
        @(posedge clk); #1;
        feed(16'h1000, y, ok);
        tests++;
        if (!ok || y !== 16'h0800) begin
            fails++;
            $display("FAIL flush_history: got %h (valid_seen=%b), want 0800", y, ok);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] y;
        bit ok;
        bit rose;
        set_impulse_coefs();
        do_flush();
        for (int i = 0; i < 8; i++) feed(16'h0400, y, ok);
        in_sample = 16'h2000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (coef_addr !== 3'd3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midmac_k3: coef_addr=%0d busy=%b, want 3/1", coef_addr, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || coef_addr !== 3'd0) begin
            fails++;
            $display("FAIL midmac_reset: busy=%b out_valid=%b coef_addr=%0d, want 0/0/0",
                     busy, out_valid, coef_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        tests++;
        if (rose) begin
            fails++;
            $display("FAIL midmac_no_output: out_valid rose=%b, want 0", rose);
        end
        @(posedge clk); #1;
        feed(16'h1000, y, ok);
        tests++;
        if (!ok || y !== 16'h0800) begin
            fails++;
            $display("FAIL midmac_next: got %h (valid_seen=%b), want 0800", y, ok);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) coefs[i] = 17'h00000;
        test_reset();
        test_impulse();
        test_latency();
        test_saturation();
        test_backpressure();
        test_flush_wrap();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
